// File: rtl/axil_reg_slave.sv
// ============================================================================
// axil_reg_slave
// ----------------------------------------------------------------------------
// AXI4-Lite responder with four 32-bit read/write registers.
//
// The AW and W channels are accepted independently, each into a one-entry
// holding buffer. Once both buffers are full, the write is committed with
// byte strobes and a write response is raised. Reads return the register
// contents with single-cycle latency. The read path is independent of the
// write path.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   S_AXI_AW*           write address channel (AWPROT ignored)
//   S_AXI_W*            write data channel with byte strobes
//   S_AXI_B*            write response channel (BRESP always OKAY)
//   S_AXI_AR*           read address channel (ARPROT ignored)
//   S_AXI_R*            read data channel (RRESP always OKAY)
//   reg_o               {reg3, reg2, reg1, reg0}
//   wr_pulse_o          bit n pulses for one cycle after regn is committed
// ============================================================================
module axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_o,
    output logic [3:0]                        wr_pulse_o
);

    localparam int NUM_REGS = 4;
    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

    // Write-side state
    logic                          aw_full_reg;
    logic [1:0]                    aw_buf_reg;
    logic                          w_full_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_buf_reg;
    logic [STRB_W-1:0]             strb_buf_reg;
    logic                          bvalid_reg;
    logic [3:0]                    wr_pulse_reg;

    // Read-side state
    logic                          rvalid_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;

    // Register file
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_reg [NUM_REGS];

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          commit;
    logic [C_S_AXI_DATA_WIDTH-1:0] wmask;
    logic [C_S_AXI_DATA_WIDTH-1:0] merged_next;

    // Readies depend only on registered state, never on the valids.
    assign S_AXI_AWREADY = !aw_full_reg && !bvalid_reg;
    assign S_AXI_WREADY  = !w_full_reg  && !bvalid_reg;
    assign S_AXI_ARREADY = !rvalid_reg;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;

    // Both halves buffered and the previous response retired.
    assign commit = aw_full_reg && w_full_reg && !bvalid_reg;

    // Expand byte strobes into a bit mask.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_mask
            assign wmask[8*gi +: 8] = {8{strb_buf_reg[gi]}};
        end
    endgenerate

    assign merged_next = (regs_reg[aw_buf_reg] & ~wmask) | (w_buf_reg & wmask);

    // Register file update
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (commit) begin
            regs_reg[aw_buf_reg] <= merged_next;
        end
    end

    // Write channel control
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full_reg  <= 1'b0;
            aw_buf_reg   <= '0;
            w_full_reg   <= 1'b0;
            w_buf_reg    <= '0;
            strb_buf_reg <= '0;
            bvalid_reg   <= 1'b0;
            wr_pulse_reg <= '0;
        end else begin
            wr_pulse_reg <= '0;
            // A handshake cannot coincide with a commit: a full buffer
            // deasserts its ready, so the two branches are exclusive.
            if (aw_hs) begin
                aw_buf_reg  <= S_AXI_AWADDR[3:2];
                aw_full_reg <= 1'b1;
            end
            if (w_hs) begin
                w_buf_reg    <= S_AXI_WDATA;
                strb_buf_reg <= S_AXI_WSTRB;
                w_full_reg   <= 1'b1;
            end
            if (commit) begin
                aw_full_reg  <= 1'b0;
                w_full_reg   <= 1'b0;
                bvalid_reg   <= 1'b1;
                wr_pulse_reg <= 4'b0001 << aw_buf_reg;
            end else if (bvalid_reg && S_AXI_BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // Read channel. The register array is sampled with the pre-edge value,
    // so a read colliding with a commit to the same register returns the
    // old contents.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= regs_reg[S_AXI_ARADDR[3:2]];
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pack
            assign reg_o[C_S_AXI_DATA_WIDTH*gi +: C_S_AXI_DATA_WIDTH] = regs_reg[gi];
        end
    endgenerate

    assign S_AXI_BRESP  = 2'b00;
    assign S_AXI_BVALID = bvalid_reg;
    assign S_AXI_RRESP  = 2'b00;
    assign S_AXI_RVALID = rvalid_reg;
    assign S_AXI_RDATA  = rdata_reg;
    assign wr_pulse_o   = wr_pulse_reg;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
